// File: rtl/seq_array_mult_pkg.sv
// Shared definitions for the sequential array multiplier.
//   state_e : FSM state encoding (idle / run / done)
//   clog2   : ceiling log2, used to size the row counter
package seq_array_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; returns 1 for values <= 2 so a counter is never zero width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 1) ? value - 1 : 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/array_row_p.sv
// One row of an unsigned array multiplier: adds the gated multiplicand to an
// incoming partial sum.
// Ports:
//   a     [WIDTH-1:0] multiplicand
//   b                 multiplier bit gating this row
//   s_in  [WIDTH-1:0] incoming partial sum
//   s_out [WIDTH-1:0] row sum
//   c_out             row carry out
module array_row_p #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
);

  logic [WIDTH-1:0] w_pp;

  assign w_pp           = a & {WIDTH{b}};
  assign {c_out, s_out} = {1'b0, s_in} + {1'b0, w_pp};

endmodule

// File: rtl/seq_array_mult.sv
// Sequential unsigned multiplier reusing a single array-multiplier row per
// clock. One product bit is retired each cycle into a low-half shift register
// while the upper half accumulates in acc.
// Optional build macro: SEQ_ARRAY_MULT_EARLY_TERM_EN finishes as soon as the
// remaining multiplier bits are zero (same results, shorter latency).
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   start   begin a multiply (honoured in idle or done)
//   a, b    [WIDTH-1:0] operands, captured on the accepted start
//   busy    high while rows are being processed
//   done    one-cycle pulse when product becomes valid
//   product [2*WIDTH-1:0] result, held until the next completion or reset
module seq_array_mult
  import seq_array_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = clog2(WIDTH);

  state_e            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_low;
  logic [CntW-1:0]   r_k;

  logic [WIDTH-1:0]   w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_low_next;
  logic               w_last;
  logic               w_finish;
  logic [2*WIDTH-1:0] w_prod;

  array_row_p #(
    .WIDTH (WIDTH)
  ) u_row (
    .a     (r_a),
    .b     (r_b[0]),
    .s_in  (r_acc),
    .s_out (w_s),
    .c_out (w_c)
  );

  // The row's LSB is final and shifts into the low half; the carry becomes
  // the new accumulator MSB.
  assign w_acc_next = {w_c, w_s[WIDTH-1:1]};
  assign w_low_next = {w_s[0], r_low[WIDTH-1:1]};
  assign w_last     = (r_k == CntW'(WIDTH - 1));

`ifdef SEQ_ARRAY_MULT_EARLY_TERM_EN
  logic               w_rest_zero;
  logic [2*WIDTH-1:0] w_full;

  assign w_rest_zero = (r_b[WIDTH-1:1] == '0);
  assign w_full      = {w_acc_next, w_low_next};
  assign w_finish    = w_last | w_rest_zero;
  // Only k+1 bits have entered the low half; align as if the zero rows ran.
  assign w_prod      = w_full >> (CntW'(WIDTH - 1) - r_k);
`else
  assign w_finish    = w_last;
  assign w_prod      = {w_acc_next, w_low_next};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_low   <= '0;
      r_k     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_low   <= '0;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= StRun;
          end else begin
            busy    <= 1'b0;
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_low <= w_low_next;
          r_b   <= r_b >> 1;
          r_k   <= r_k + CntW'(1);
          if (w_finish) begin
            product <= w_prod;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
